fetch_unit: RTL

Program-counter and instruction-fetch stage sitting directly upstream of the `alu` execute stage. It holds the PC, requests instructions from instruction memory over a req/ack handshake, and presents each fetched word to decode/execute with a valid/stall handshake. It consumes the ALU's `branch` result and a branch target to redirect the PC, and stops on a decoded halt.

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Program-counter and instruction-fetch stage feeding the alu execute stage.
// It keeps the PC, fetches one instruction at a time from instruction memory
// over a req/ack handshake, and offers each fetched word downstream with a
// valid/stall handshake. A taken branch from the ALU redirects the PC, and a
// decoded halt parks the unit until the next start.
//
// Parameters:
//   pc_width     PC and instruction-memory address width
//   instr_width  instruction word width
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   start          begin execution at PC 0 (honoured in IDLE and HALT only)
//   imem_addr      fetch address, always equal to pc
//   imem_req       registered fetch request
//   imem_ack       memory returns imem_data this cycle (used only in REQ)
//   imem_data      fetched instruction word
//   instr          current instruction for decode/ALU
//   instr_valid    instr is valid
//   stall          downstream cannot consume instr this cycle
//   branch         ALU branch-taken flag for instr
//   branch_target  next PC when branch is taken
//   halt_in        decode reports instr is a halt
//   pc             address of the current/pending instruction
//   done           program halted
module fetch_unit #(
    parameter int pc_width    = 10,
    parameter int instr_width = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [pc_width-1:0]    imem_addr,
    output logic                   imem_req,
    input  logic                   imem_ack,
    input  logic [instr_width-1:0] imem_data,
    output logic [instr_width-1:0] instr,
    output logic                   instr_valid,
    input  logic                   stall,
    input  logic                   branch,
    input  logic [pc_width-1:0]    branch_target,
    input  logic                   halt_in,
    output logic [pc_width-1:0]    pc,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE,
        HALT
    } state_t;

    state_t state, state_next;

    logic [pc_width-1:0]    pc_q, pc_next;
    logic                   imem_req_q, imem_req_next;
    logic [instr_width-1:0] instr_q, instr_next;
    logic                   instr_valid_q, instr_valid_next;
    logic                   done_q, done_next;

    // The downstream stage has taken the current instruction this cycle.
    logic consume;
    assign consume = (state == ISSUE) && !stall;

    // State and output registers. Reset wins over everything else in the
    // same cycle, so an ack arriving together with reset is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc_q          <= '0;
            imem_req_q    <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_next;
            pc_q          <= pc_next;
            imem_req_q    <= imem_req_next;
            instr_q       <= instr_next;
            instr_valid_q <= instr_valid_next;
            done_q        <= done_next;
        end
    end

    // Next-state logic. Start is only looked at while idle or halted, and a
    // stalled instruction pins the unit in ISSUE regardless of branch/halt.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = REQ;
            REQ:   if (imem_ack) state_next = ISSUE;
            ISSUE: begin
                if (consume) begin
                    state_next = halt_in ? HALT : REQ;
                end
            end
            HALT:  if (start) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs. Every output holds by default;
    // instr in particular keeps its last word after instr_valid drops. Halt
    // outranks branch, and the sequential increment wraps naturally at the
    // top of the address space.
    always_comb begin
        pc_next          = pc_q;
        imem_req_next    = imem_req_q;
        instr_next       = instr_q;
        instr_valid_next = instr_valid_q;
        done_next        = done_q;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_next       = '0;
                    imem_req_next = 1'b1;
                    done_next     = 1'b0;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_next       = imem_data;
                    instr_valid_next = 1'b1;
                    imem_req_next    = 1'b0;
                end
            end
            ISSUE: begin
                if (consume) begin
                    instr_valid_next = 1'b0;
                    if (halt_in) begin
                        done_next = 1'b1;
                    end else begin
                        imem_req_next = 1'b1;
                        if (branch) begin
                            pc_next = branch_target;
                        end else begin
                            pc_next = pc_q + pc_width'(1);
                        end
                    end
                end
            end
            default: begin
                pc_next = pc_q;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign done        = done_q;

endmodule
